// File: rtl/mem_bus_master.sv
// MOV/MOC memory bus initiator: one load/store at a time, 4-phase handshake, size-extended read data.
// Optional macro BUS_TIMEOUT_EN aborts a handshake if MOC stalls for TIMEOUT_CYC cycles.
module mem_bus_master #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mov,
  output logic              rw,
  output logic [ADDR_W-1:0] mar,
  output logic [1:0]        mem_size,
  output logic [31:0]       data_to_mem,
  input  logic              moc,
  input  logic [31:0]       data_from_mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       cap_q, cap_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misaligned;
  logic              tmo_expired;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic sgn);
    case (sz)
      2'b00:   extend = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{sgn & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Reloaded on every entry into a wait state; expiry is judged on the current count.
  always_comb begin
    tmo_d = tmo_q;
    if ((state_d != state_q) && ((state_d == S_ASSERT) || (state_d == S_RELEASE))) begin
      tmo_d = TMO_RELOAD;
    end else if (tmo_q != '0) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_expired = (tmo_q == '0);
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = misaligned ? S_ERR : S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (moc) begin
          state_d = S_RELEASE;
        end else if (tmo_expired) begin
          state_d = S_ERR;
        end
      end
      S_RELEASE: begin
        if (!moc) begin
          state_d = S_DONE;
        end else if (tmo_expired) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mov  = (state_q == S_ASSERT);
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    err  = (state_q == S_ERR);
  end

  always_comb begin
    rw_d    = rw_q;
    mar_d   = mar_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    if ((state_q == S_IDLE) && req) begin
      rw_d    = req_rw;
      mar_d   = req_addr;
      size_d  = req_size;
      sgn_d   = req_signed;
      wdata_d = req_wdata;
    end
    if ((state_q == S_ASSERT) && moc && rw_q) begin
      cap_d = data_from_mem;
    end
    // rdata changes only on a successful load, in step with the done pulse.
    if ((state_q == S_RELEASE) && (state_d == S_DONE) && rw_q) begin
      rdata_d = extend(cap_q, size_q, sgn_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q    <= 1'b1;
      mar_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      rw_q    <= rw_d;
      mar_q   <= mar_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign rw          = rw_q;
  assign mar         = mar_q;
  assign mem_size    = size_q;
  assign data_to_mem = wdata_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: driver pushes expected outcomes, a negedge monitor checks them.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_rw = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, done, err, mov, rw;
  logic [31:0] rdata, mar, data_to_mem;
  logic [1:0]  mem_size;
  logic        moc = 1'b0;
  logic [31:0] data_from_mem = '0;

  mem_bus_master #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .mov(mov), .rw(rw),
    .mar(mar), .mem_size(mem_size), .data_to_mem(data_to_mem),
    .moc(moc), .data_from_mem(data_from_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          tmo;
    bit          rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] model_rdata = '0;
  bit          resp_hold = 1'b0;
  bit          resp_fast = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic logic [31:0] model_ext(input int sz, input bit sg, input logic [31:0] d);
    longint span, v;
    if (sz == 2) return d;
    span = longint'(1) << (8 << sz);
    v = longint'(d) % span;
    if (sg && v >= span / 2) v -= span;
    return 32'(v);
  endfunction

  // Memory responder: random wait before MOC, random hold after MOV drops.
  initial begin
    int d, n;
    forever begin
      @(posedge clk); #1;
      if (!reset && mov && !moc && !resp_hold) begin
        d = resp_fast ? 0 : $urandom_range(0, 3);
        repeat (d) begin @(posedge clk); #1; end
        data_from_mem = (resp_q.size() != 0) ? resp_q.pop_front() : $urandom;
        moc = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (mov && n < 100);
        d = resp_fast ? 0 : $urandom_range(0, 2);
        repeat (d) begin @(posedge clk); #1; end
        moc = 1'b0;
        data_from_mem = $urandom;
      end
    end
  end

  // Monitor
  initial begin
    bit prev_done = 0, mov_seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 0;
        mov_seen  = 0;
        continue;
      end
      if (mov) begin
        mov_seen = 1;
        if (exp_q.size() == 0) begin
          check("mov_unexpected", 1, 0);
        end else begin
          e = exp_q[0];
          check("mov_allowed", 32'(e.is_err && !e.tmo), 0);
          check("bus_mar", mar, e.addr);
          check("bus_rw", 32'(rw), 32'(e.rw));
          check("bus_size", 32'(mem_size), 32'(e.size));
          if (!e.rw) check("bus_wdata", data_to_mem, e.wdata);
        end
      end
      if (done || err) begin
        check("done_err_overlap", 32'(done && err), 0);
        check("busy_at_end", 32'(busy), 1);
        check("mov_at_end", 32'(mov), 0);
        if (exp_q.size() == 0) begin
          check("end_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check(done ? "done_vs_err" : "err_vs_done", 32'(err), 32'(e.is_err));
          check("rdata", rdata, e.rdata);
          check("mov_seen", 32'(mov_seen), 32'(!e.is_err || e.tmo));
        end
        mov_seen = 0;
      end
      if (done) check("done_one_cycle", 32'(prev_done), 0);
      prev_done = done;
    end
  end

  task automatic issue(input bit rwv, input logic [1:0] sz, input bit sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] md, input bit tmo, output int lat);
    exp_t e;
    int n;
    bit bad;
    bad = (sz == 2'b11) || ((ad % (32'd1 << sz)) != 0);
    e.is_err = bad || tmo;
    e.tmo    = tmo;
    e.rw     = rwv;
    e.addr   = ad;
    e.size   = sz;
    e.wdata  = wd;
    if (!bad && !tmo) begin
      resp_q.push_back(md);
      if (rwv) model_rdata = model_ext(int'(sz), sg, md);
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; req_rw = rwv; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk); #1;
    n = 0;
    // Garbage requests while busy must be ignored.
    while (!(done || err) && n < 100) begin
      req = 1'($urandom_range(0, 1)); req_rw = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    if (n >= 100) check("handshake_bound", 32'(n), 0);
    lat = n;
  endtask

  initial begin
    int lat;
    exp_t e;
    // Reset values
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mov", 32'(mov), 0);
    check("rst_rw", 32'(rw), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;

    // Directed cases with a zero-wait responder
    issue(1, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, lat);
    check("lat_word_read", 32'(lat), 2);
    issue(1, 2'b00, 1, 32'h3, 32'h0, 32'h000000F0, 0, lat);
    issue(1, 2'b00, 0, 32'h3, 32'h0, 32'h000000F0, 0, lat);
    issue(0, 2'b01, 0, 32'h6, 32'h00001234, 32'h0BADF00D, 0, lat);
    check("lat_half_write", 32'(lat), 2);
    issue(1, 2'b10, 0, 32'h2, 32'h0, 32'h0, 0, lat);
    check("lat_misaligned_err", 32'(lat), 0);
    issue(1, 2'b11, 1, 32'h8, 32'h0, 32'h0, 0, lat);
    check("lat_size11_err", 32'(lat), 0);
    issue(1, 2'b01, 1, 32'h22, 32'h0, 32'h12348001, 0, lat);

    // Reset for two cycles in the middle of ASSERT
    resp_hold = 1'b1;
    e = '{is_err: 0, tmo: 0, rw: 1, addr: 32'h40, size: 2'b10, wdata: 32'h0, rdata: model_rdata};
    exp_q.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_signed = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_pre_mov", 32'(mov), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      exp_q.delete();
      resp_q.delete();
      model_rdata = '0;
      check("rst_mid_mov", 32'(mov), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_done_err", 32'({done, err}), 0);
      check("rst_mid_rw", 32'(rw), 1);
      check("rst_mid_mar", mar, 0);
      check("rst_mid_size", 32'(mem_size), 0);
      check("rst_mid_wdata", data_to_mem, 0);
      check("rst_mid_rdata", rdata, 0);
    end
    reset = 1'b0;
    resp_hold = 1'b0;

    // Randomized traffic with a variable-latency responder
    resp_fast = 1'b0;
    for (int i = 0; i < 250; i++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
            $urandom, $urandom, 0, lat);
    end

`ifdef BUS_TIMEOUT_EN
    resp_hold = 1'b1;
    issue(1, 2'b10, 0, 32'h100, 32'h0, 32'h0, 1, lat);
    check("tmo_latency", 32'(lat), 16);
    check("tmo_mov", 32'(mov), 0);
    @(posedge clk); #1;
    check("tmo_busy_after", 32'(busy), 0);
    resp_hold = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("responses_drained", 32'(resp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
